slow_tick_bcd_counter: RTL and testbench

- Sits directly downstream of the divided slow clock (e.g. 11 Hz) and runs entirely on the fast system clock.
- Treats the slow clock as asynchronous data: synchronises it and turns each rising edge into a one-cycle tick.
- Each tick advances a 2-digit BCD up/down counter.
- The counter value drives a multiplexed 2-digit 7-segment display on the board.

---
 rtl/slow_tick_bcd_counter.sv | 165 ++++++++++++++++
 tb/tb_slow_tick_bcd_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/slow_tick_bcd_counter.sv
// slow_tick_bcd_counter
// Synchronises a divided slow clock into the system clock domain, turns each
// of its rising edges into a one-cycle tick, advances a 2-digit BCD up/down
// counter on every tick, and scans the two digits onto a multiplexed,
// active-low 7-segment display.
module slow_tick_bcd_counter #(
  parameter int MAX_COUNT   = 59,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       enable,
  input  logic       up_down,
  input  logic       clear,
  output logic       tick,
  output logic [3:0] count_ones,
  output logic [3:0] count_tens,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             r_tick;
  logic             r_wrap;
  logic [3:0]       r_ones;
  logic [3:0]       r_tens;
  logic [REF_W-1:0] r_refCnt;
  logic             r_digitSel;
  logic [6:0]       r_seg;
  logic [1:0]       r_an;

  logic             w_rise;
  logic [3:0]       w_onesNext;
  logic [3:0]       w_tensNext;
  logic             w_wrapNext;
  logic [3:0]       w_digit;
  logic [6:0]       w_segDecoded;

  assign w_rise = r_s2 & ~r_s3;

  // Three-flop synchroniser; resets high so a slow clock already high at
  // reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= slow_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Next counter value: clear wins, then an enabled tick counts up or down
  // with BCD carry/borrow and wrap at the 0 / MAX_COUNT boundaries.
  always_comb begin
    w_onesNext = r_ones;
    w_tensNext = r_tens;
    w_wrapNext = 1'b0;
    if (clear) begin
      w_onesNext = 4'd0;
      w_tensNext = 4'd0;
    end else if (w_rise && enable && up_down) begin
      if (r_ones == MAX_ONES && r_tens == MAX_TENS) begin
        w_onesNext = 4'd0;
        w_tensNext = 4'd0;
        w_wrapNext = 1'b1;
      end else if (r_ones == 4'd9) begin
        w_onesNext = 4'd0;
        w_tensNext = r_tens + 4'd1;
      end else begin
        w_onesNext = r_ones + 4'd1;
      end
    end else if (w_rise && enable && !up_down) begin
      if (r_ones == 4'd0 && r_tens == 4'd0) begin
        w_onesNext = MAX_ONES;
        w_tensNext = MAX_TENS;
        w_wrapNext = 1'b1;
      end else if (r_ones == 4'd0) begin
        w_onesNext = 4'd9;
        w_tensNext = r_tens - 4'd1;
      end else begin
        w_onesNext = r_ones - 4'd1;
      end
    end
  end

  // Tick, wrap and counter digits all register on the same edge so the
  // count changes together with the tick pulse.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else begin
      r_tick <= w_rise;
      r_wrap <= w_wrapNext;
      r_ones <= w_onesNext;
      r_tens <= w_tensNext;
    end
  end

  // Display refresh timer; the digit select flips each time it wraps.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_refCnt   <= '0;
      r_digitSel <= 1'b0;
    end else if (r_refCnt == REF_LAST) begin
      r_refCnt   <= '0;
      r_digitSel <= ~r_digitSel;
    end else begin
      r_refCnt <= r_refCnt + 1'b1;
    end
  end

  assign w_digit = r_digitSel ? r_tens : r_ones;

  // Active-low gfedcba decode of the currently selected digit.
  always_comb begin
    w_segDecoded = 7'b1111111;
    case (w_digit)
      4'd0: w_segDecoded = 7'b1000000;
      4'd1: w_segDecoded = 7'b1111001;
      4'd2: w_segDecoded = 7'b0100100;
      4'd3: w_segDecoded = 7'b0110000;
      4'd4: w_segDecoded = 7'b0011001;
      4'd5: w_segDecoded = 7'b0010010;
      4'd6: w_segDecoded = 7'b0000010;
      4'd7: w_segDecoded = 7'b1111000;
      4'd8: w_segDecoded = 7'b0000000;
      4'd9: w_segDecoded = 7'b0010000;
      default: w_segDecoded = 7'b1111111;
    endcase
  end

  // Anode and segment outputs register together so they never disagree.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_an  <= 2'b10;
      r_seg <= 7'b1000000;
    end else begin
      r_an  <= r_digitSel ? 2'b01 : 2'b10;
      r_seg <= w_segDecoded;
    end
  end

  assign tick       = r_tick;
  assign wrap       = r_wrap;
  assign count_ones = r_ones;
  assign count_tens = r_tens;
  assign seg        = r_seg;
  assign an         = r_an;

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// tb_slow_tick_bcd_counter
// Directed bench: every slow-clock rising edge pushes the expected counter
// result onto a scoreboard queue, which is popped when the DUT ticks.
module tb_slow_tick_bcd_counter;

  typedef struct {
    int   value;
    logic wrapExp;
  } expEntry_t;

  logic       clockIn;
  logic       reset;
  logic       slowClk;
  logic       enable;
  logic       upDown;
  logic       clear;
  logic       tick;
  logic [3:0] countOnes;
  logic [3:0] countTens;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;

  int        checks;
  int        errors;
  int        modelCount;
  int        wrapsSeen;
  int        tickCount;
  expEntry_t scoreboard[$];

  slow_tick_bcd_counter #(
    .MAX_COUNT  (59),
    .REFRESH_DIV(4)
  ) dut (
    .clock_in  (clockIn),
    .reset     (reset),
    .slow_clk  (slowClk),
    .enable    (enable),
    .up_down   (upDown),
    .clear     (clear),
    .tick      (tick),
    .count_ones(countOnes),
    .count_tens(countTens),
    .wrap      (wrap),
    .seg       (seg),
    .an        (an)
  );

  // Free-running 100 MHz system clock.
  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  task automatic checkOutput(input string name, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Drive one slow-clock rising edge, predict the result, then wait for the
  // tick and compare against the popped prediction.
  task automatic applyStimulus();
    expEntry_t e;
    logic      seen;
    e.wrapExp = 1'b0;
    if (clear) begin
      e.value = 0;
    end else if (enable && upDown) begin
      if (modelCount == 59) begin
        e.value   = 0;
        e.wrapExp = 1'b1;
      end else begin
        e.value = modelCount + 1;
      end
    end else if (enable && !upDown) begin
      if (modelCount == 0) begin
        e.value   = 59;
        e.wrapExp = 1'b1;
      end else begin
        e.value = modelCount - 1;
      end
    end else begin
      e.value = modelCount;
    end
    modelCount = e.value;
    scoreboard.push_back(e);

    @(negedge clockIn);
    slowClk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clockIn);
      if (tick) seen = 1'b1;
    end
    checkOutput("tickWithinLatency", 16'(seen), 16'd1);
    e = scoreboard.pop_front();
    if (seen) begin
      tickCount++;
      if (wrap) wrapsSeen++;
      checkOutput("countOnes", 16'(countOnes), 16'(e.value % 10));
      checkOutput("countTens", 16'(countTens), 16'(e.value / 10));
      checkOutput("wrapOnTick", 16'(wrap), 16'(e.wrapExp));
      @(negedge clockIn);
      checkOutput("tickOneCycle", 16'(tick), 16'd0);
      checkOutput("wrapOneCycle", 16'(wrap), 16'd0);
    end
    slowClk = 1'b0;
    repeat (4) @(negedge clockIn);
  endtask

  initial begin
    logic [1:0] prevAn;
    int         runLen;
    int         transitions;
    logic       found;

    checks     = 0;
    errors     = 0;
    modelCount = 0;
    wrapsSeen  = 0;
    tickCount  = 0;
    reset      = 1'b1;
    slowClk    = 1'b1;
    enable     = 1'b1;
    upDown     = 1'b1;
    clear      = 1'b0;

    // Reset state, then release with the slow clock held high.
    repeat (3) @(negedge clockIn);
    checkOutput("resetAn", 16'(an), 16'b10);
    checkOutput("resetSeg", 16'(seg), 16'b1000000);
    checkOutput("resetCount", {8'd0, countTens, countOnes}, 16'h0000);
    checkOutput("resetTick", 16'(tick), 16'd0);
    checkOutput("resetWrap", 16'(wrap), 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clockIn);
      checkOutput("noTickHighAtRelease", 16'(tick), 16'd0);
    end
    slowClk = 1'b0;
    repeat (4) @(negedge clockIn);

    // First edge counts 00 -> 01, then 59 more up to wrap back to 00.
    applyStimulus();
    wrapsSeen = 0;
    for (int i = 0; i < 59; i++) applyStimulus();
    checkOutput("upWrapCount", 16'(wrapsSeen), 16'd1);
    checkOutput("upEndsAtZero", {8'd0, countTens, countOnes}, 16'h0000);

    // Count down across the 00 boundary, then borrow from 10 to 09.
    upDown = 1'b0;
    applyStimulus();
    applyStimulus();
    clear = 1'b1;
    applyStimulus();
    clear  = 1'b0;
    upDown = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus();
    upDown = 1'b0;
    applyStimulus();
    checkOutput("borrowTo09", {8'd0, countTens, countOnes}, 16'h0009);

    // Reach 37, then clear coincident with a rising edge.
    upDown = 1'b1;
    for (int i = 0; i < 28; i++) applyStimulus();
    checkOutput("reached37", {8'd0, countTens, countOnes}, 16'h0037);
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;

    // Climb to 42, then five edges with enable low still tick but hold.
    for (int i = 0; i < 42; i++) applyStimulus();
    enable    = 1'b0;
    tickCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus();
    enable = 1'b1;
    checkOutput("disabledTicks", 16'(tickCount), 16'd5);
    checkOutput("heldAt42", {8'd0, countTens, countOnes}, 16'h0042);

    // Display scan: four cycles per digit, segments matching the anode.
    @(negedge clockIn);
    prevAn      = an;
    runLen      = 1;
    transitions = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clockIn);
      if (an == 2'b10) checkOutput("segOnes", 16'(seg), 16'b0100100);
      else             checkOutput("segTens", 16'(seg), 16'b0011001);
      if (an != prevAn) begin
        if (transitions > 0) checkOutput("anRunLength", 16'(runLen), 16'd4);
        transitions++;
        runLen = 1;
      end else begin
        runLen++;
      end
      prevAn = an;
    end
    checkOutput("anToggled", 16'(transitions >= 8), 16'd1);

    // Asynchronous reset while the tens digit is showing.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clockIn);
      if (an == 2'b01) found = 1'b1;
    end
    checkOutput("tensSlotReached", 16'(found), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetAn", 16'(an), 16'b10);
    checkOutput("asyncResetSeg", 16'(seg), 16'b1000000);
    checkOutput("asyncResetCount", {8'd0, countTens, countOnes}, 16'h0000);
    @(negedge clockIn);
    reset      = 1'b0;
    modelCount = 0;
    slowClk    = 1'b0;
    repeat (4) @(negedge clockIn);
    applyStimulus();
    checkOutput("resumeFrom00", {8'd0, countTens, countOnes}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
